// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the router input stage and the switch allocator.
// The router side uses master; the allocator uses slave.
interface switch_allocator_if #(
    parameter int NUM_PORTS = 5,
    parameter int CREDIT_W  = 3
);
    logic [NUM_PORTS-1:0]           req_valid_i;
    logic [NUM_PORTS*NUM_PORTS-1:0] req_dir_i;
    logic [NUM_PORTS-1:0]           req_tail_i;
    logic [NUM_PORTS*CREDIT_W-1:0]  credit_all_i;
    logic [NUM_PORTS*NUM_PORTS-1:0] grant_o;
    logic [NUM_PORTS-1:0]           send_data_o;
    logic [NUM_PORTS-1:0]           counter_minus_o;
    logic [NUM_PORTS-1:0]           out_busy_o;
    logic                           proto_err_o;

    modport master (
        output req_valid_i, req_dir_i, req_tail_i, credit_all_i,
        input  grant_o, send_data_o, counter_minus_o, out_busy_o,
        input  proto_err_o
    );

    modport slave (
        input  req_valid_i, req_dir_i, req_tail_i, credit_all_i,
        output grant_o, send_data_o, counter_minus_o, out_busy_o,
        output proto_err_o
    );
endinterface

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator: round-robin among heads, lock
// from head to tail, credit-gated transfers, sticky protocol error.
module switch_allocator #(
    parameter int NUM_PORTS = 5,
    parameter int CREDIT_W  = 3
) (
    input logic               clk,
    input logic               rst,
    switch_allocator_if.slave bus
);
    localparam int IW = $clog2(NUM_PORTS);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              fsm       [NUM_PORTS];
    state_t              fsm_nxt   [NUM_PORTS];
    logic [IW-1:0]       owner     [NUM_PORTS];
    logic [IW-1:0]       owner_nxt [NUM_PORTS];
    logic [IW-1:0]       ptr       [NUM_PORTS];
    logic [IW-1:0]       ptr_nxt   [NUM_PORTS];
    logic                err;
    logic                err_nxt;

    logic [NUM_PORTS-1:0] req [NUM_PORTS];
    logic [NUM_PORTS-1:0] bad_dir;

    logic [NUM_PORTS*NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0]           send;
    logic [NUM_PORTS-1:0]           cminus;
    logic [NUM_PORTS-1:0]           busy;

    // Decode each input's head into a per-output request; flag bad dirs.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            bad_dir[i] = bus.req_valid_i[i] &&
                !$onehot(bus.req_dir_i[NUM_PORTS*i +: NUM_PORTS]);
            for (int o = 0; o < NUM_PORTS; o++) begin
                req[i][o] = bus.req_valid_i[i] && !bad_dir[i] &&
                    bus.req_dir_i[NUM_PORTS*i + o];
            end
        end
    end

    // Arbitration, credit gating and next-state for every output.
    always_comb begin
        logic found;
        int   g;
        int   idx;
        grant   = '0;
        send    = '0;
        cminus  = '0;
        err_nxt = err | (|bad_dir);
        found   = 1'b0;
        g       = 0;
        idx     = 0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            fsm_nxt[o]   = fsm[o];
            owner_nxt[o] = owner[o];
            ptr_nxt[o]   = ptr[o];
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            found = 1'b0;
            g     = 0;
            if (fsm[o] == IDLE) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = int'(ptr[o]) + k;
                    if (idx >= NUM_PORTS) idx -= NUM_PORTS;
                    if (!found && req[idx][o]) begin
                        found = 1'b1;
                        g     = idx;
                    end
                end
            end else begin
                g     = int'(owner[o]);
                found = req[g][o];
                // A locked owner pointing elsewhere breaks the packet.
                if (bus.req_valid_i[g] && !req[g][o]) err_nxt = 1'b1;
            end
            if (found && bus.credit_all_i[CREDIT_W*o +: CREDIT_W] != '0) begin
                grant[NUM_PORTS*o + g] = 1'b1;
                send[g]                = 1'b1;
                cminus[o]              = 1'b1;
                if (fsm[o] == IDLE) begin
                    ptr_nxt[o] = (g == NUM_PORTS-1) ? '0 : IW'(g + 1);
                    if (!bus.req_tail_i[g]) begin
                        fsm_nxt[o]   = LOCKED;
                        owner_nxt[o] = IW'(g);
                    end
                end else if (bus.req_tail_i[g]) begin
                    fsm_nxt[o] = IDLE;
                end
            end
        end
    end

    // State registers; reset drops every lock at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                fsm[o]   <= IDLE;
                owner[o] <= '0;
                ptr[o]   <= '0;
            end
            err <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                fsm[o]   <= fsm_nxt[o];
                owner[o] <= owner_nxt[o];
                ptr[o]   <= ptr_nxt[o];
            end
            err <= err_nxt;
        end
    end

    // Busy comes from the registered lock state only.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            busy[o] = (fsm[o] == LOCKED);
        end
    end

    assign bus.grant_o         = rst ? grant  : '0;
    assign bus.send_data_o     = rst ? send   : '0;
    assign bus.counter_minus_o = rst ? cminus : '0;
    assign bus.out_busy_o      = rst ? busy   : '0;
    assign bus.proto_err_o     = rst ? err    : 1'b0;
endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: per-scenario stimulus tables,
// expectations queued at drive time and compared on the falling edge.
module tb_switch_allocator;
    logic clk;
    logic rst;

    switch_allocator_if bus ();

    switch_allocator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [4:0]  valid;
        logic [24:0] dir;
        logic [4:0]  tail;
        logic [14:0] credit;
    } stim_t;

    typedef struct packed {
        logic [24:0] grant;
        logic [4:0]  send;
        logic [4:0]  cm;
        logic [4:0]  busy;
        logic        err;
    } obs_t;

    typedef struct packed {
        stim_t s;
        obs_t  e;
    } step_t;

    localparam logic [14:0] ALL7 = 15'o77777;

    obs_t exp_q [$];
    int   total  = 0;
    int   passed = 0;

    function automatic logic [24:0] dr(int i, int o);
        logic [24:0] v;
        v = '0;
        v[5*i + o] = 1'b1;
        return v;
    endfunction

    function automatic logic [24:0] gb(int o, int i);
        logic [24:0] v;
        v = '0;
        v[5*o + i] = 1'b1;
        return v;
    endfunction

    function automatic stim_t st(logic r, logic [4:0] v, logic [24:0] d,
                                 logic [4:0] t, logic [14:0] c);
        stim_t s;
        s.rst = r; s.valid = v; s.dir = d; s.tail = t; s.credit = c;
        return s;
    endfunction

    function automatic obs_t ex(logic [24:0] g, logic [4:0] s,
                                logic [4:0] c, logic [4:0] b, logic e);
        obs_t x;
        x.grant = g; x.send = s; x.cm = c; x.busy = b; x.err = e;
        return x;
    endfunction

    function automatic step_t sp(stim_t s, obs_t e);
        step_t x;
        x.s = s; x.e = e;
        return x;
    endfunction

    function automatic obs_t sample();
        obs_t x;
        x.grant = bus.grant_o;
        x.send  = bus.send_data_o;
        x.cm    = bus.counter_minus_o;
        x.busy  = bus.out_busy_o;
        x.err   = bus.proto_err_o;
        return x;
    endfunction

    task automatic drive(stim_t s);
        rst              = s.rst;
        bus.req_valid_i  = s.valid;
        bus.req_dir_i    = s.dir;
        bus.req_tail_i   = s.tail;
        bus.credit_all_i = s.credit;
    endtask

    task automatic reset_dut();
        drive(st(1'b0, 5'b0, 25'b0, 5'b0, ALL7));
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        step_t steps [$];
        obs_t  got, want;
        logic [24:0] all_n;
        all_n = dr(0,4) | dr(1,4) | dr(2,4) | dr(3,4) | dr(4,4);
        steps.push_back(sp(st(1'b0, 5'b11111, all_n, 5'b11111, ALL7),
                           ex('0, 5'b0, 5'b0, 5'b0, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b11111, all_n, 5'b11111, ALL7),
                           ex(gb(4,0), 5'b00001, 5'b10000, 5'b0, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b11111, all_n, 5'b11111, ALL7),
                           ex(gb(4,1), 5'b00010, 5'b10000, 5'b0, 1'b0)));
        foreach (steps[k]) begin
            drive(steps[k].s);
            exp_q.push_back(steps[k].e);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want)
                $display("FAIL reset step %0d: got g=%h s=%b c=%b b=%b e=%b want g=%h s=%b c=%b b=%b e=%b",
                    k, got.grant, got.send, got.cm, got.busy, got.err,
                    want.grant, want.send, want.cm, want.busy, want.err);
            else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_round_robin();
        step_t steps [$];
        obs_t  got, want;
        logic [24:0] d;
        int order [4] = '{1, 3, 4, 1};
        reset_dut();
        d = dr(4,3) | dr(3,3) | dr(1,3);
        foreach (order[j])
            steps.push_back(sp(st(1'b1, 5'b11010, d, 5'b11111, ALL7),
                ex(gb(3, order[j]), 5'(1 << order[j]), 5'b01000, 5'b0, 1'b0)));
        foreach (steps[k]) begin
            drive(steps[k].s);
            exp_q.push_back(steps[k].e);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want)
                $display("FAIL round_robin step %0d: got g=%h s=%b c=%b b=%b e=%b want g=%h s=%b c=%b b=%b e=%b",
                    k, got.grant, got.send, got.cm, got.busy, got.err,
                    want.grant, want.send, want.cm, want.busy, want.err);
            else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_wormhole();
        step_t steps [$];
        obs_t  got, want;
        reset_dut();
        steps.push_back(sp(st(1'b1, 5'b00100, dr(2,1), 5'b00000, ALL7),
            ex(gb(1,2), 5'b00100, 5'b00010, 5'b00000, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b00101, dr(2,1) | dr(0,1), 5'b00001, ALL7),
            ex(gb(1,2), 5'b00100, 5'b00010, 5'b00010, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b00101, dr(2,1) | dr(0,1), 5'b00101, ALL7),
            ex(gb(1,2), 5'b00100, 5'b00010, 5'b00010, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b00001, dr(0,1), 5'b00001, ALL7),
            ex(gb(1,0), 5'b00001, 5'b00010, 5'b00000, 1'b0)));
        foreach (steps[k]) begin
            drive(steps[k].s);
            exp_q.push_back(steps[k].e);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want)
                $display("FAIL wormhole step %0d: got g=%h s=%b c=%b b=%b e=%b want g=%h s=%b c=%b b=%b e=%b",
                    k, got.grant, got.send, got.cm, got.busy, got.err,
                    want.grant, want.send, want.cm, want.busy, want.err);
            else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_credit_stall();
        step_t steps [$];
        obs_t  got, want;
        reset_dut();
        steps.push_back(sp(st(1'b1, 5'b01000, dr(3,4), 5'b0, ALL7),
            ex(gb(4,3), 5'b01000, 5'b10000, 5'b00000, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b01000, dr(3,4), 5'b0, 15'o07777),
            ex('0, 5'b0, 5'b0, 5'b10000, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b01000, dr(3,4), 5'b0, 15'o07777),
            ex('0, 5'b0, 5'b0, 5'b10000, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b01000, dr(3,4), 5'b0, 15'o17777),
            ex(gb(4,3), 5'b01000, 5'b10000, 5'b10000, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b01000, dr(3,4), 5'b01000, ALL7),
            ex(gb(4,3), 5'b01000, 5'b10000, 5'b10000, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b0, 25'b0, 5'b0, ALL7),
            ex('0, 5'b0, 5'b0, 5'b0, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b01000, dr(3,4), 5'b0, ALL7),
            ex(gb(4,3), 5'b01000, 5'b10000, 5'b00000, 1'b0)));
        steps.push_back(sp(st(1'b0, 5'b01000, dr(3,4), 5'b0, ALL7),
            ex('0, 5'b0, 5'b0, 5'b0, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b0, 25'b0, 5'b0, ALL7),
            ex('0, 5'b0, 5'b0, 5'b0, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b00100, dr(2,4), 5'b00100, ALL7),
            ex(gb(4,2), 5'b00100, 5'b10000, 5'b0, 1'b0)));
        foreach (steps[k]) begin
            drive(steps[k].s);
            exp_q.push_back(steps[k].e);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want)
                $display("FAIL credit_stall step %0d: got g=%h s=%b c=%b b=%b e=%b want g=%h s=%b c=%b b=%b e=%b",
                    k, got.grant, got.send, got.cm, got.busy, got.err,
                    want.grant, want.send, want.cm, want.busy, want.err);
            else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_errors();
        step_t steps [$];
        obs_t  got, want;
        logic [24:0] bad;
        reset_dut();
        bad = '0;
        bad[14:10] = 5'b00110;
        steps.push_back(sp(st(1'b1, 5'b00010, dr(1,2), 5'b0, ALL7),
            ex(gb(2,1), 5'b00010, 5'b00100, 5'b00000, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b00010, dr(1,0), 5'b0, 15'o77770),
            ex('0, 5'b0, 5'b0, 5'b00100, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b0, 25'b0, 5'b0, ALL7),
            ex('0, 5'b0, 5'b0, 5'b00100, 1'b1)));
        steps.push_back(sp(st(1'b1, 5'b0, 25'b0, 5'b0, ALL7),
            ex('0, 5'b0, 5'b0, 5'b00100, 1'b1)));
        steps.push_back(sp(st(1'b0, 5'b0, 25'b0, 5'b0, ALL7),
            ex('0, 5'b0, 5'b0, 5'b0, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b0, 25'b0, 5'b0, ALL7),
            ex('0, 5'b0, 5'b0, 5'b0, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b00100, bad, 5'b00100, ALL7),
            ex('0, 5'b0, 5'b0, 5'b0, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b0, 25'b0, 5'b0, ALL7),
            ex('0, 5'b0, 5'b0, 5'b0, 1'b1)));
        steps.push_back(sp(st(1'b1, 5'b00001, dr(0,0), 5'b00001, ALL7),
            ex(gb(0,0), 5'b00001, 5'b00001, 5'b0, 1'b1)));
        foreach (steps[k]) begin
            drive(steps[k].s);
            exp_q.push_back(steps[k].e);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want)
                $display("FAIL errors step %0d: got g=%h s=%b c=%b b=%b e=%b want g=%h s=%b c=%b b=%b e=%b",
                    k, got.grant, got.send, got.cm, got.busy, got.err,
                    want.grant, want.send, want.cm, want.busy, want.err);
            else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_parallel();
        step_t steps [$];
        obs_t  got, want;
        logic [24:0] d;
        logic [24:0] g;
        reset_dut();
        d = '0;
        g = '0;
        for (int i = 0; i < 5; i++) begin
            d = d | dr(i, (i + 1) % 5);
            g = g | gb((i + 1) % 5, i);
        end
        steps.push_back(sp(st(1'b1, 5'b11111, d, 5'b11111, ALL7),
            ex(g, 5'b11111, 5'b11111, 5'b00000, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b11111, d, 5'b00000, ALL7),
            ex(g, 5'b11111, 5'b11111, 5'b00000, 1'b0)));
        steps.push_back(sp(st(1'b1, 5'b00000, 25'b0, 5'b00000, ALL7),
            ex('0, 5'b0, 5'b0, 5'b11111, 1'b0)));
        foreach (steps[k]) begin
            drive(steps[k].s);
            exp_q.push_back(steps[k].e);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            total++;
            if (got !== want)
                $display("FAIL parallel step %0d: got g=%h s=%b c=%b b=%b e=%b want g=%h s=%b c=%b b=%b e=%b",
                    k, got.grant, got.send, got.cm, got.busy, got.err,
                    want.grant, want.send, want.cm, want.busy, want.err);
            else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        drive(st(1'b0, 5'b0, 25'b0, 5'b0, ALL7));
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credit_stall();
        test_errors();
        test_parallel();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
